music_seq_rtl: RTL and testbench

MUSIC_SEQ_RTL -- requirements
Module: music_seq_rtl

---
 rtl/music_seq_rtl.sv | 115 +++++++++++
 tb/tb_music_seq_rtl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/music_seq_rtl.sv
// Song sequencer: fetches note words from memory at a per-song base and plays each for BEAT_CYCLES.
// Memory response is combinational; pause freezes PLAY, loop_en restarts the song at its end marker.
module music_seq_rtl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SONG_W      = 4,
  parameter int SONG_SHIFT  = 9,
  parameter int MAX_WORDS   = 128,
  parameter int BEAT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [SONG_W-1:0]            song_sel,
  input  logic                         loop_en,
  input  logic                         pause,
  output logic                         memreq_val,
  output logic [ADDR_W-1:0]            memreq_addr,
  input  logic [DATA_W-1:0]            memresp_data,
  output logic [2:0]                   note,
  output logic                         note_val,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_WORDS):0]   word_idx
);

  localparam int IW = $clog2(MAX_WORDS) + 1;
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [IW-1:0]     r_idx;
  logic [BW-1:0]     r_beat;
  logic [2:0]        r_note;

  logic              w_song_end;
  logic [2:0]        w_note;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [IW-1:0]     w_idx_nxt;
  logic              w_last;

  assign w_song_end = &memresp_data;
  // Codes above 7 (other than the end marker) play as a rest.
  assign w_note     = (memresp_data < DATA_W'(8)) ? memresp_data[2:0] : 3'd0;
  assign w_base     = ADDR_W'(song_sel) << SONG_SHIFT;
  assign w_addr_nxt = r_addr + ADDR_W'(DATA_W / 8);
  assign w_idx_nxt  = r_idx + IW'(1);
  assign w_last     = (w_idx_nxt == IW'(MAX_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_beat  <= '0;
      r_note  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= w_base;
            r_addr  <= w_base;
            r_idx   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_song_end) begin
            if (loop_en) begin
              r_addr <= r_base;
              r_idx  <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_note  <= w_note;
            r_beat  <= BW'(BEAT_CYCLES - 1);
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (r_beat != '0) begin
              r_beat <= r_beat - BW'(1);
            end else if (w_last && loop_en) begin
              // Word limit reached with looping: behave exactly like an end marker.
              r_addr  <= r_base;
              r_idx   <= '0;
              r_state <= S_FETCH;
            end else begin
              r_addr  <= w_addr_nxt;
              r_idx   <= w_idx_nxt;
              r_state <= w_last ? S_DONE : S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign memreq_val  = (r_state == S_FETCH);
  assign memreq_addr = (r_state == S_FETCH) ? r_addr : '0;
  assign note        = r_note;
  assign note_val    = (r_state == S_PLAY) && !pause;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign word_idx    = r_idx;

endmodule

// File: tb/tb_music_seq_rtl.sv
// Bench for music_seq_rtl: table-driven cycle vectors plus hand sequences, checked through a scoreboard queue.
module tb_music_seq_rtl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  song_sel;
  logic        loop_en;
  logic        pause;
  logic        memreq_val;
  logic [15:0] memreq_addr;
  logic [31:0] memresp_data;
  logic [2:0]  note;
  logic        note_val;
  logic        busy;
  logic        done;
  logic [2:0]  word_idx;
  logic        mem_mode;

  typedef struct packed {
    logic        mv;
    logic [15:0] addr;
    logic [2:0]  note;
    logic        nv;
    logic        busy;
    logic        done;
    logic [2:0]  idx;
  } out_t;

  typedef struct packed {
    logic       r;
    logic       s;
    logic [4:0] sel;
    logic       le;
    logic       pa;
    out_t       exp;
  } vec_t;

  out_t exp_q[$];
  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  music_seq_rtl #(
    .ADDR_W(16), .DATA_W(32), .SONG_W(5), .SONG_SHIFT(9),
    .MAX_WORDS(4), .BEAT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .song_sel(song_sel),
    .loop_en(loop_en), .pause(pause),
    .memreq_val(memreq_val), .memreq_addr(memreq_addr), .memresp_data(memresp_data),
    .note(note), .note_val(note_val), .busy(busy), .done(done), .word_idx(word_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode 0: 3, rest, end marker.  Mode 1: four playable words, no end marker.
  always_comb begin
    memresp_data = '1;
    if (!mem_mode) begin
      case (memreq_addr)
        16'h0000: memresp_data = 32'd3;
        16'h0004: memresp_data = 32'd0;
        default:  memresp_data = '1;
      endcase
    end else begin
      case (memreq_addr)
        16'h0000: memresp_data = 32'd1;
        16'h0004: memresp_data = 32'd2;
        16'h0008: memresp_data = 32'd5;
        16'h000C: memresp_data = 32'd9;
        default:  memresp_data = '1;
      endcase
    end
  end

  function automatic out_t o(input logic mv, input logic [15:0] a, input logic [2:0] n,
                             input logic nv, input logic b, input logic d, input logic [2:0] i);
    out_t t;
    t.mv = mv; t.addr = a; t.note = n; t.nv = nv; t.busy = b; t.done = d; t.idx = i;
    return t;
  endfunction

  function automatic vec_t v(input logic r, input logic s, input logic [4:0] sel,
                             input logic le, input logic pa, input out_t e);
    vec_t t;
    t.r = r; t.s = s; t.sel = sel; t.le = le; t.pa = pa; t.exp = e;
    return t;
  endfunction

  task automatic check(input string nm);
    out_t e;
    out_t g;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got output with no expectation", nm);
      return;
    end
    e = exp_q.pop_front();
    g = {memreq_val, memreq_addr, note, note_val, busy, done, word_idx};
    if (g !== e)
      $display("FAIL %s #%0d: got mv=%0b addr=%h note=%0d nv=%0b busy=%0b done=%0b idx=%0d, expected mv=%0b addr=%h note=%0d nv=%0b busy=%0b done=%0b idx=%0d",
               nm, n_total, g.mv, g.addr, g.note, g.nv, g.busy, g.done, g.idx,
               e.mv, e.addr, e.note, e.nv, e.busy, e.done, e.idx);
    else
      n_pass++;
  endtask

  // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
  task automatic step(input string nm, input logic r, input logic s, input logic [4:0] sel,
                      input logic le, input logic pa, input out_t e);
    rst = r; start = s; song_sel = sel; loop_en = le; pause = pa;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check(nm);
  endtask

  task automatic play4_fetch(input string nm, input logic [2:0] n, input logic [2:0] i,
                             input logic [15:0] naddr, input logic [2:0] ni, input logic le);
    for (int k = 0; k < 4; k++) step(nm, 0, 0, 0, le, 0, o(0, 16'h0, n, 1, 1, 0, i));
    step(nm, 0, 0, 0, le, 0, o(1, naddr, n, 0, 1, 0, ni));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; song_sel = '0; loop_en = 1'b0; pause = 1'b0; mem_mode = 1'b0;

    // Reset, basic play of song 0, then song-select base addresses.
    tbl.push_back(v(1, 1, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 0, 0, 0, o(1, 16'h0000, 0, 0, 1, 0, 0)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 3, 1, 1, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(1, 16'h0004, 3, 0, 1, 0, 1)));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1, 0, 1)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(1, 16'h0008, 0, 0, 1, 0, 2)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 1, 1, 2)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 2)));
    tbl.push_back(v(0, 1, 1, 0, 0, o(1, 16'h0200, 0, 0, 1, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 1, 1, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 17, 0, 0, o(1, 16'h2200, 0, 0, 1, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 1, 1, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0)));

    @(negedge clk);
    foreach (tbl[k]) step("table", tbl[k].r, tbl[k].s, tbl[k].sel, tbl[k].le, tbl[k].pa, tbl[k].exp);

    // Looping: end marker returns to the base with no done, then finishes once loop_en drops.
    step("loop_start", 0, 1, 0, 1, 0, o(1, 16'h0000, 0, 0, 1, 0, 0));
    play4_fetch("loop_w0", 3, 0, 16'h0004, 1, 1);
    play4_fetch("loop_w1", 0, 1, 16'h0008, 2, 1);
    step("loop_wrap", 0, 0, 0, 1, 0, o(1, 16'h0000, 0, 0, 1, 0, 0));
    play4_fetch("loop2_w0", 3, 0, 16'h0004, 1, 0);
    play4_fetch("loop2_w1", 0, 1, 16'h0008, 2, 0);
    step("loop_done", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 1, 1, 2));
    step("loop_idle", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 2));

    // Pause mid-note, start while busy, then reset during PLAY.
    step("pause_start", 0, 1, 0, 0, 0, o(1, 16'h0000, 0, 0, 1, 0, 0));
    step("pause_play", 0, 0, 0, 0, 0, o(0, 16'h0, 3, 1, 1, 0, 0));
    step("pause_play", 0, 0, 0, 0, 0, o(0, 16'h0, 3, 1, 1, 0, 0));
    for (int k = 0; k < 3; k++) step("paused", 0, 0, 0, 0, 1, o(0, 16'h0, 3, 0, 1, 0, 0));
    step("busy_start", 0, 1, 3, 0, 0, o(0, 16'h0, 3, 1, 1, 0, 0));
    step("pause_play", 0, 0, 0, 0, 0, o(0, 16'h0, 3, 1, 1, 0, 0));
    step("pause_fetch", 0, 0, 0, 0, 0, o(1, 16'h0004, 3, 0, 1, 0, 1));
    step("pause_rest", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1, 0, 1));
    step("rst_play", 1, 1, 2, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0));
    step("rst_after", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0));
    step("rst_after", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 0));

    // Word limit: no end marker, exactly four fetches then done.
    mem_mode = 1'b1;
    step("max_start", 0, 1, 0, 0, 0, o(1, 16'h0000, 0, 0, 1, 0, 0));
    play4_fetch("max_w0", 1, 0, 16'h0004, 1, 0);
    play4_fetch("max_w1", 2, 1, 16'h0008, 2, 0);
    play4_fetch("max_w2", 5, 2, 16'h000C, 3, 0);
    for (int k = 0; k < 4; k++) step("max_w3", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 1, 1, 0, 3));
    step("max_done", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 1, 1, 4));
    step("max_idle", 0, 0, 0, 0, 0, o(0, 16'h0, 0, 0, 0, 0, 4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
